per_uart_tx: RTL and testbench

// - Memory-mapped transmit-only UART peripheral on the openMSP430 peripheral bus (per_en/per_we/per_addr/per_din/per_dout).
// - CPU writes bytes into an internal FIFO; an 8N1 serializer shifts them out LSB-first on uart_txd at a programmable rate.
// - Sits directly downstream of the CPU peripheral port, beside the bench memory models; its per_dout is OR-combined onto the CPU's per_dout input.

---
 rtl/per_uart_tx_if.sv | 24 ++
 rtl/per_uart_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_per_uart_tx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/per_uart_tx_if.sv
// openMSP430 peripheral bus: CPU-side strobes and data toward a peripheral, read data back.
interface per_uart_tx_if;
    logic        per_en;
    logic [1:0]  per_we;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic [15:0] per_dout;

    modport master (
        output per_en,
        output per_we,
        output per_addr,
        output per_din,
        input  per_dout
    );

    modport slave (
        input  per_en,
        input  per_we,
        input  per_addr,
        input  per_din,
        output per_dout
    );
endinterface

// File: rtl/per_uart_tx.sv
// Transmit-only 8N1 UART on the openMSP430 peripheral bus: CPU pushes bytes into a
// small FIFO and a serializer shifts them out LSB-first at BAUD+1 mclk cycles per bit.
module per_uart_tx #(
    parameter logic [13:0] BASE_ADDR = 14'h0040,
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] BAUD_RST  = 16'd7
) (
    input  logic            mclk,
    input  logic            puc_rst,
    per_uart_tx_if.slave    bus,
    output logic            uart_txd,
    output logic            irq_tx_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = AW + 1;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_TXDATA = 2'd2;
    localparam logic [1:0] OFF_BAUD   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Register decode
    logic       sel;
    logic [1:0] reg_off;
    logic       wr_ctrl_lo;
    logic       wr_stat_hi;
    logic       wr_baud_lo;
    logic       wr_baud_hi;
    logic       push_req;

    assign sel        = bus.per_en && (bus.per_addr[13:2] == BASE_ADDR[13:2]);
    assign reg_off    = bus.per_addr[1:0];
    assign wr_ctrl_lo = sel && (reg_off == OFF_CTRL)   && bus.per_we[0];
    assign wr_stat_hi = sel && (reg_off == OFF_STATUS) && bus.per_we[1];
    assign push_req   = sel && (reg_off == OFF_TXDATA) && bus.per_we[0];
    assign wr_baud_lo = sel && (reg_off == OFF_BAUD)   && bus.per_we[0];
    assign wr_baud_hi = sel && (reg_off == OFF_BAUD)   && bus.per_we[1];

    // Control / baud registers
    logic        ctrl_en;
    logic        ctrl_irq_en;
    logic        ctrl_irq_en_next;
    logic [15:0] baud;
    logic        ovf;

    assign ctrl_irq_en_next = wr_ctrl_lo ? bus.per_din[1] : ctrl_irq_en;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            baud        <= BAUD_RST;
        end else begin
            if (wr_ctrl_lo) begin
                ctrl_en     <= bus.per_din[0];
                ctrl_irq_en <= bus.per_din[1];
            end
            if (wr_baud_lo) baud[7:0]  <= bus.per_din[7:0];
            if (wr_baud_hi) baud[15:8] <= bus.per_din[15:8];
        end
    end

    // FIFO
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] level_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_ok;

    assign fifo_full  = (level == LW'(DEPTH));
    assign fifo_empty = (level == '0);
    assign push_ok    = push_req && (!fifo_full || pop);

    always_comb begin
        level_next = level;
        if (push_ok && !pop)      level_next = level + LW'(1);
        else if (pop && !push_ok) level_next = level - LW'(1);
    end

    always_ff @(posedge mclk) begin
        if (push_ok) mem[wr_ptr] <= bus.per_din[7:0];
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            level <= level_next;
        end
    end

    // Overflow flag: a dropped byte wins over a same-cycle clear
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            ovf <= 1'b0;
        end else if (push_req && !push_ok) begin
            ovf <= 1'b1;
        end else if (wr_stat_hi && bus.per_din[8]) begin
            ovf <= 1'b0;
        end
    end

    // Serializer state register
    state_t      state;
    state_t      state_next;
    logic [15:0] baud_cnt;
    logic [15:0] baud_cnt_next;
    logic [15:0] bit_len;
    logic [15:0] bit_len_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_next;
    logic [7:0]  shift;
    logic [7:0]  shift_next;
    logic        bit_end;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_len  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_len  <= bit_len_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
        end
    end

    // bit_len latches BAUD at each bit start so a mid-bit write applies from the next bit
    assign bit_end = (baud_cnt == bit_len);

    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + 16'd1;
        bit_len_next  = bit_len;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (ctrl_en && !fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = mem[rd_ptr];
                    bit_len_next = baud;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    bit_len_next  = baud;
                    bit_idx_next  = '0;
                    state_next    = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    bit_len_next  = baud;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from next-state values so the registered outputs align with the state
    logic txd_next;
    logic irq_next;

    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            default: txd_next = 1'b1;
        endcase
        irq_next = ctrl_irq_en_next && (level_next == '0) && (state_next == IDLE);
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            uart_txd     <= 1'b1;
            irq_tx_empty <= 1'b0;
        end else begin
            uart_txd     <= txd_next;
            irq_tx_empty <= irq_next;
        end
    end

    // Combinational read mux, zero when not selected so it can be OR-combined
    logic [15:0] rdata;

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_off)
                OFF_CTRL:   rdata = {14'd0, ctrl_irq_en, ctrl_en};
                OFF_STATUS: rdata = {7'd0, ovf, 4'(level), 1'b0, fifo_empty, fifo_full,
                                     (state != IDLE)};
                OFF_TXDATA: rdata = '0;
                OFF_BAUD:   rdata = baud;
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.per_dout = rdata;

endmodule

// File: tb/tb_per_uart_tx.sv
// Directed self-checking bench for per_uart_tx: register map, frame timing, FIFO limits, reset.
module tb_per_uart_tx;

    localparam logic [13:0] BASE = 14'h0040;

    logic mclk;
    logic puc_rst;
    logic uart_txd;
    logic irq_tx_empty;

    int checks   = 0;
    int failures = 0;

    per_uart_tx_if bus();

    per_uart_tx #(
        .BASE_ADDR(14'h0040),
        .DEPTH    (8),
        .BAUD_RST (16'd7)
    ) dut (
        .mclk        (mclk),
        .puc_rst     (puc_rst),
        .bus         (bus),
        .uart_txd    (uart_txd),
        .irq_tx_empty(irq_tx_empty)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Bus access helpers: called at a negedge, return at the following negedge
    task automatic bus_write(input logic [1:0] off, input logic [1:0] we, input logic [15:0] data);
        bus.per_en   = 1'b1;
        bus.per_we   = we;
        bus.per_addr = BASE + 14'(off);
        bus.per_din  = data;
        @(negedge mclk);
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [15:0] data);
        bus.per_en   = 1'b1;
        bus.per_we   = 2'b00;
        bus.per_addr = BASE + 14'(off);
        #1;
        data = bus.per_dout;
        @(negedge mclk);
        bus.per_en   = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        puc_rst = 1'b1;
        repeat (2) @(negedge mclk);
        puc_rst = 1'b0;
        @(negedge mclk);
        checks++;
        if (uart_txd !== 1'b1) begin failures++; $display("FAIL reset_txd got %b exp 1", uart_txd); end
        checks++;
        if (irq_tx_empty !== 1'b0) begin failures++; $display("FAIL reset_irq got %b exp 0", irq_tx_empty); end
        checks++;
        if (bus.per_dout !== 16'h0000) begin failures++; $display("FAIL reset_dout_idle got %h exp 0000", bus.per_dout); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 16'h0004) begin failures++; $display("FAIL reset_status got %h exp 0004", d); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 16'h0000) begin failures++; $display("FAIL reset_ctrl got %h exp 0000", d); end
        bus_read(2'd3, d);
        checks++;
        if (d !== 16'h0007) begin failures++; $display("FAIL reset_baud got %h exp 0007", d); end
        // Unselected word address must read zero even with per_en high
        bus.per_en = 1'b1; bus.per_we = 2'b00; bus.per_addr = 14'h0044;
        #1;
        checks++;
        if (bus.per_dout !== 16'h0000) begin failures++; $display("FAIL unsel_read got %h exp 0000", bus.per_dout); end
        @(negedge mclk);
        bus.per_en = 1'b0;
    endtask

    task automatic test_frame_a5();
        logic [7:0] byte_v;
        logic       exp;
        int         n;
        int         idx;
        byte_v = 8'hA5;
        bus_write(2'd3, 2'b11, 16'd3);
        bus_write(2'd0, 2'b01, 16'h0001);
        bus_write(2'd2, 2'b01, 16'h00A5);
        n = 0;
        while (uart_txd !== 1'b0 && n < 50) begin @(negedge mclk); n++; end
        checks++;
        if (n >= 50) begin failures++; $display("FAIL a5_start_timeout got %0d cycles exp <50", n); end
        for (int i = 0; i < 40; i++) begin
            bus.per_en = 1'b1; bus.per_we = 2'b00; bus.per_addr = BASE + 14'd1;
            #1;
            idx = i / 4;
            if (idx == 0)      exp = 1'b0;
            else if (idx == 9) exp = 1'b1;
            else               exp = byte_v[idx-1];
            checks++;
            if (uart_txd !== exp) begin failures++; $display("FAIL a5_txd cyc=%0d got %b exp %b", i, uart_txd, exp); end
            checks++;
            if (bus.per_dout[0] !== 1'b1) begin failures++; $display("FAIL a5_busy cyc=%0d got %b exp 1", i, bus.per_dout[0]); end
            @(negedge mclk);
        end
        #1;
        checks++;
        if (uart_txd !== 1'b1) begin failures++; $display("FAIL a5_idle_txd got %b exp 1", uart_txd); end
        checks++;
        if (bus.per_dout[0] !== 1'b0) begin failures++; $display("FAIL a5_idle_busy got %b exp 0", bus.per_dout[0]); end
        @(negedge mclk);
        bus.per_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        bus_write(2'd0, 2'b01, 16'h0000);
        for (int i = 0; i < 9; i++) bus_write(2'd2, 2'b01, 16'(i));
        bus_read(2'd1, d);
        checks++;
        if (d !== 16'h0182) begin failures++; $display("FAIL ovf_status got %h exp 0182", d); end
        bus_write(2'd1, 2'b11, 16'h0100);
        bus_read(2'd1, d);
        checks++;
        if (d !== 16'h0082) begin failures++; $display("FAIL ovf_clear got %h exp 0082", d); end
    endtask

    task automatic test_full_pop();
        logic [15:0] d;
        int          n;
        // Enable, then push in the very cycle the IDLE state pops the head
        bus_write(2'd0, 2'b01, 16'h0001);
        bus_write(2'd2, 2'b01, 16'h0009);
        bus_read(2'd1, d);
        checks++;
        if (d !== 16'h0083) begin failures++; $display("FAIL fullpop_status got %h exp 0083", d); end
        bus_write(2'd3, 2'b11, 16'h0000);
        n = 0;
        d = 16'hFFFF;
        while (d !== 16'h0004 && n < 1000) begin bus_read(2'd1, d); n++; end
        checks++;
        if (d !== 16'h0004) begin failures++; $display("FAIL fullpop_drain got %h exp 0004", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] byte_a;
        logic       exp_txd;
        logic       exp_irq;
        int         n;
        byte_a = 8'h55;
        bus_write(2'd0, 2'b01, 16'h0000);
        bus_write(2'd2, 2'b01, 16'h0055);
        bus_write(2'd2, 2'b01, 16'h00FF);
        bus_write(2'd0, 2'b01, 16'h0003);
        n = 0;
        while (uart_txd !== 1'b0 && n < 20) begin @(negedge mclk); n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL b2b_start_timeout got %0d cycles exp <20", n); end
        for (int i = 0; i < 22; i++) begin
            if (i == 0 || i == 11) exp_txd = 1'b0;
            else if (i >= 1 && i <= 8) exp_txd = byte_a[i-1];
            else exp_txd = 1'b1;
            exp_irq = (i == 21);
            checks++;
            if (uart_txd !== exp_txd) begin failures++; $display("FAIL b2b_txd cyc=%0d got %b exp %b", i, uart_txd, exp_txd); end
            checks++;
            if (irq_tx_empty !== exp_irq) begin failures++; $display("FAIL b2b_irq cyc=%0d got %b exp %b", i, irq_tx_empty, exp_irq); end
            @(negedge mclk);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        int          n;
        bus_write(2'd0, 2'b01, 16'h0000);
        bus_write(2'd3, 2'b11, 16'd3);
        bus_write(2'd2, 2'b01, 16'h0000);
        bus_write(2'd2, 2'b01, 16'h0001);
        bus_write(2'd0, 2'b01, 16'h0001);
        n = 0;
        while (uart_txd !== 1'b0 && n < 20) begin @(negedge mclk); n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL rst_start_timeout got %0d cycles exp <20", n); end
        repeat (17) @(negedge mclk);
        checks++;
        if (uart_txd !== 1'b0) begin failures++; $display("FAIL rst_bit3_before got %b exp 0", uart_txd); end
        puc_rst = 1'b1;
        #1;
        checks++;
        if (uart_txd !== 1'b1) begin failures++; $display("FAIL rst_async_txd got %b exp 1", uart_txd); end
        @(negedge mclk);
        puc_rst = 1'b0;
        @(negedge mclk);
        bus_read(2'd1, d);
        checks++;
        if (d !== 16'h0004) begin failures++; $display("FAIL rst_status got %h exp 0004", d); end
        bus_read(2'd3, d);
        checks++;
        if (d !== 16'h0007) begin failures++; $display("FAIL rst_baud got %h exp 0007", d); end
        // High-lane-only TXDATA write must not push
        bus_write(2'd2, 2'b10, 16'h1234);
        bus_read(2'd1, d);
        checks++;
        if (d !== 16'h0004) begin failures++; $display("FAIL txdata_hi_ignored got %h exp 0004", d); end
        bus_read(2'd2, d);
        checks++;
        if (d !== 16'h0000) begin failures++; $display("FAIL txdata_read got %h exp 0000", d); end
    endtask

    initial begin
        puc_rst      = 1'b1;
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
        bus.per_addr = '0;
        bus.per_din  = '0;
        @(negedge mclk);
        test_reset();
        test_frame_a5();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
